// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register file write arbiter with zeroing sweep
module regfile_write_arbiter #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int ZERO_X0 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v0,
  input  logic [AW-1:0] a0,
  input  logic [DW-1:0] d0,
  output logic          r0,
  input  logic          v1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  output logic          r1,
  input  logic          flush,
  input  logic          init_req,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          xfer0, xfer1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
    end
  end

  // Grants look only at valids and the pointer, never at address or data.
  always_comb begin
    r0 = 1'b0;
    r1 = 1'b0;
    if (state_q == ST_RUN && !flush && !init_req) begin
      if (v0 && (!v1 || !ptr_q)) begin
        r0 = 1'b1;
      end else if (v1) begin
        r1 = 1'b1;
      end
    end
  end

  assign xfer0 = v0 & r0;
  assign xfer1 = v1 & r1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we3_d   = 1'b0;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    case (state_q)
      ST_INIT: begin
        we3_d = 1'b1;
        wa3_d = cnt_q;
        wd3_d = '0;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (xfer0) begin
          // A write to x0 is still acknowledged, just not committed.
          we3_d = !((ZERO_X0 != 0) && (a0 == '0));
          wa3_d = a0;
          wd3_d = d0;
          ptr_d = 1'b1;
        end else if (xfer1) begin
          we3_d = !((ZERO_X0 != 0) && (a1 == '0));
          wa3_d = a1;
          wd3_d = d1;
          ptr_d = 1'b0;
        end
      end
    endcase
  end

  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, flush, init_req;
  logic [2:0] a0, a1;
  logic [7:0] d0, d1;

  logic       r0, r1, we3, init_done;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic       nz_r0, nz_r1, nz_we3, nz_init_done;
  logic [2:0] nz_wa3;
  logic [7:0] nz_wd3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DW(8), .AW(3), .ZERO_X0(1)) dut (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .flush(flush), .init_req(init_req),
    .we3(we3), .wa3(wa3), .wd3(wd3), .init_done(init_done)
  );

  regfile_write_arbiter #(.DW(8), .AW(3), .ZERO_X0(0)) dut_nz (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .d0(d0), .r0(nz_r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(nz_r1),
    .flush(flush), .init_req(init_req),
    .we3(nz_we3), .wa3(nz_wa3), .wd3(nz_wd3), .init_done(nz_init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; init_req = 1'b0;
    v0 = 1'b1; a0 = 3'd3; d0 = 8'h55;
    v1 = 1'b0; a1 = 3'd0; d1 = 8'h00;

    // Reset state with a request pending that must be dropped
    #2;
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_r0", r0, 0);
    check("rst_r1", r1, 0);
    check("rst_init_done", init_done, 0);
    step();
    check("rst_hold_we3", we3, 0);

    // Initial zero sweep
    rst = 1'b1; v0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("sweep_we3_%0d", i), we3, 1);
      check($sformatf("sweep_wa3_%0d", i), wa3, i);
      check($sformatf("sweep_wd3_%0d", i), wd3, 0);
    end
    step();
    check("sweep_end_we3", we3, 0);
    check("sweep_end_done", init_done, 1);
    check("nz_sweep_end_done", nz_init_done, 1);

    // Contention, ptr=0: requester 0 first, then requester 1
    v0 = 1'b1; a0 = 3'd2; d0 = 8'h11;
    v1 = 1'b1; a1 = 3'd5; d1 = 8'h22;
    #1;
    check("rr_first_r0", r0, 1);
    check("rr_first_r1", r1, 0);
    step();
    check("rr_w1_we3", we3, 1);
    check("rr_w1_wa3", wa3, 2);
    check("rr_w1_wd3", wd3, 8'h11);
    check("rr_second_r0", r0, 0);
    check("rr_second_r1", r1, 1);
    step();
    check("rr_w2_we3", we3, 1);
    check("rr_w2_wa3", wa3, 5);
    check("rr_w2_wd3", wd3, 8'h22);
    check("rr_third_r0", r0, 1);
    v0 = 1'b0; v1 = 1'b0;
    step();
    check("idle_we3", we3, 0);
    check("idle_wa3_hold", wa3, 5);
    check("idle_wd3_hold", wd3, 8'h22);

    // Write to x0 from requester 1
    v1 = 1'b1; a1 = 3'd0; d1 = 8'hFF;
    #1;
    check("x0_r1", r1, 1);
    check("x0_r0", r0, 0);
    step();
    check("x0_we3", we3, 0);
    check("x0_nz_we3", nz_we3, 1);
    check("x0_nz_wa3", nz_wa3, 0);
    check("x0_nz_wd3", nz_wd3, 8'hFF);
    v1 = 1'b0;

    // Contention with ptr=1: requester 1 wins
    v0 = 1'b1; a0 = 3'd6; d0 = 8'h33;
    #1;
    check("solo0_r0", r0, 1);
    step();
    check("solo0_wa3", wa3, 6);
    check("solo0_wd3", wd3, 8'h33);
    v1 = 1'b1; a1 = 3'd1; d1 = 8'h44;
    #1;
    check("ptr1_r1", r1, 1);
    check("ptr1_r0", r0, 0);
    step();
    check("ptr1_we3", we3, 1);
    check("ptr1_wa3", wa3, 1);
    check("ptr1_wd3", wd3, 8'h44);
    check("ptr1_next_r0", r0, 1);
    v0 = 1'b0; v1 = 1'b0;
    step();

    // Flush held for two cycles with requester 0 valid
    v0 = 1'b1; flush = 1'b1;
    #1;
    check("flush_c0_r0", r0, 0);
    check("flush_c0_we3", we3, 0);
    step();
    check("flush_c1_r0", r0, 0);
    check("flush_c1_we3", we3, 0);
    step();
    check("flush_c2_we3", we3, 0);
    flush = 1'b0;
    #1;
    check("flush_drop_r0", r0, 1);
    step();
    check("flush_after_we3", we3, 1);
    check("flush_after_wa3", wa3, 6);
    check("flush_after_wd3", wd3, 8'h33);

    // init_req with v0 pending: sweep, then grant
    a0 = 3'd4; d0 = 8'h77; init_req = 1'b1;
    #1;
    check("ireq_r0", r0, 0);
    step();
    init_req = 1'b0;
    check("ireq_done", init_done, 0);
    check("ireq_we3", we3, 0);
    check("ireq_init_r0", r0, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("resweep_we3_%0d", k), we3, 1);
      check($sformatf("resweep_wa3_%0d", k), wa3, k);
      check($sformatf("resweep_wd3_%0d", k), wd3, 0);
      if (k < 7) check($sformatf("resweep_r0_%0d", k), r0, 0);
      if (k == 3) begin
        flush = 1'b1; init_req = 1'b1;
      end else begin
        flush = 1'b0; init_req = 1'b0;
      end
    end
    check("resweep_done", init_done, 1);
    check("resweep_grant_r0", r0, 1);
    step();
    check("resweep_w_we3", we3, 1);
    check("resweep_w_wa3", wa3, 4);
    check("resweep_w_wd3", wd3, 8'h77);
    v0 = 1'b0;

    // Reset asserted mid-sweep at cnt=4
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("mid_wa3_before", wa3, 3);
    rst = 1'b0;
    #1;
    check("mid_rst_we3", we3, 0);
    check("mid_rst_wa3", wa3, 0);
    check("mid_rst_wd3", wd3, 0);
    check("mid_rst_done", init_done, 0);
    step();
    check("mid_rst_hold_we3", we3, 0);
    rst = 1'b1;
    step();
    check("restart_we3", we3, 1);
    check("restart_wa3", wa3, 0);
    step();
    check("restart_wa3_1", wa3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width, equal to the register file word width.
REQ-002 The block SHALL have parameter AW, default 3, meaning register address width (2**AW registers).
REQ-003 The block SHALL have parameter ZERO_X0, default 1; when 1, register 0 is never written outside INIT.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
  - clk  input  1  sole clock; all flops on its rising edge.
  - rst  input  1  asynchronous, active-low reset.
  - v0  input  1  requester 0 (ALU writeback) write valid.
  - a0  input  AW  requester 0 address.
  - d0  input  DW  requester 0 data.
  - r0  output  1  requester 0 ready (grant).
  - v1, a1, d1, r1  same as above, requester 1 (load writeback).
  - flush  input  1  synchronous pipeline flush.
  - init_req  input  1  one-cycle request to re-zero all registers.
  - we3  output  1  register file write enable.
  - wa3  output  AW  register file write address.
  - wd3  output  DW  register file write data.
  - init_done  output  1  high when the block is in RUN.

Function
REQ-005 The block SHALL implement a two-state FSM: INIT and RUN.
REQ-006 The block SHALL register we3, wa3 and wd3; they SHALL change only on clk rising edges or on reset.
REQ-007 In INIT, each cycle SHALL drive we3=1, wa3=cnt, wd3=0, then increment the AW-bit counter cnt.
REQ-008 In INIT, the write of cnt=2**AW-1 SHALL be followed by the transition to RUN on the next edge, with cnt reset to 0.
REQ-009 In INIT, r0 and r1 SHALL be 0, and flush and init_req SHALL be ignored.
REQ-010 In RUN, init_req=1 SHALL move the FSM to INIT on the next edge, with cnt=0, r0=r1=0 in that cycle, and no grant issued.
REQ-011 In RUN with flush=0 and init_req=0, grants SHALL be combinational as follows:
  - only v0 high: r0=1.
  - only v1 high: r1=1.
  - both high: ready to the requester selected by round-robin pointer ptr (0 selects requester 0).
  - neither high: r0=r1=0.
REQ-012 r0 and r1 SHALL never both be 1 in the same cycle.
REQ-013 A transfer SHALL occur when vi=1 and ri=1 in the same cycle; ready SHALL not depend on the other requester's address or data.
REQ-014 After a transfer from requester i, ptr SHALL become 1-i on the next edge; with no transfer, ptr SHALL hold.
REQ-015 A transfer SHALL appear on the register file port exactly one cycle later: wa3=ai and wd3=di.
REQ-016 For that transferred write, we3 SHALL be 1, except we3=0 when ZERO_X0=1 and ai=0; the transfer is still acknowledged.
REQ-017 In any RUN cycle with no transfer, the next edge SHALL set we3=0, and wa3/wd3 SHALL hold their values.
REQ-018 flush=1 in RUN SHALL force r0=r1=0 and set we3=0 on the next edge; a write already registered on we3 in the flush cycle completes.
REQ-019 init_done SHALL be 1 exactly when the FSM is in RUN.
REQ-020 A requester not granted SHALL be allowed to hold vi high, and the block SHALL grant it no later than the second cycle of contention.

Reset
REQ-021 While rst=0, the block SHALL hold: state=INIT, cnt=0, ptr=0, we3=0, wa3=0, wd3=0, r0=r1=0, init_done=0.
REQ-022 These reset values SHALL apply asynchronously on the falling edge of rst, including mid-INIT or mid-transfer.
REQ-023 After rst deasserts, the first rising edge SHALL produce we3=1, wa3=0.
REQ-024 The INIT sweep SHALL run for 2**AW cycles, with init_done=1 from the following edge.
REQ-025 A request pending during reset SHALL be lost and not replayed.

Verification
REQ-026 Release rst, v0=v1=0 -> we3=1 with wa3=0..7, wd3=0 on edges 1-8; we3=0 and init_done=1 after edge 9.
REQ-027 RUN, ptr=0: v0=v1=1 held, a0=2/d0=8'h11, a1=5/d1=8'h22 -> r0 first, then r1. Register port shows (2,11) then (5,22) on consecutive cycles.
REQ-028 RUN: v1=1, a1=0, d1=8'hFF -> r1=1, next cycle we3=0. With ZERO_X0=0 -> we3=1, wa3=0, wd3=FF.
REQ-029 RUN: v0=1 and flush=1 for 2 cycles -> r0=0 and we3=0 throughout. On flush drop, r0=1 in the same cycle.
REQ-030 RUN: init_req pulse with v0=1 -> no grant, init_done=0 next cycle, 8-cycle zero sweep, then v0 is granted.
REQ-031 Assert rst=0 mid-INIT at cnt=4 -> outputs zero immediately. Release -> sweep restarts at wa3=0.
